div_iterative: RTL and testbench
================================

Name: div_iterative

Overview:
- Unsigned 32-bit sequential divider for the MIPS datapath.
- Serves DIVU and the magnitude core of DIV: the HI/LO register path takes Hi = remainder, Lo = quotient.
- Restoring radix-2 algorithm, one quotient bit per clock.
- Start/done handshake: validIn starts a division, validOut flags the result.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- validIn  input  1  start strobe; sampled on the rising clk edge.
- SrcA  input  WIDTH  dividend (unsigned).
- SrcB  input  WIDTH  divisor (unsigned).
- validOut  output  1  result valid (level).
- Hi  output  WIDTH  remainder.
- Lo  output  WIDTH  quotient.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (reset_n).
  - While reset_n = 0: state IDLE, validOut = 0, Hi = 0, Lo = 0, counter = 0, internal registers = 0.
  - Reset mid-operation aborts the division immediately; no result is produced.
- States: IDLE, BUSY, DONE.
- IDLE or DONE, validIn = 1 at an edge:
  - Capture SrcA into the quotient/dividend shift register and SrcB into the divisor register.
  - Clear the partial remainder, load counter = WIDTH, go to BUSY, drop validOut to 0 on that same edge.
  - Operands need only be valid on the capture edge and may change afterwards.
- BUSY, each edge:
  - Shift {rem, quo} left by 1.
  - Trial subtract: t = rem_shifted − divisor, computed at WIDTH+1 bits.
  - If t ≥ 0: rem = t and quotient LSB = 1. Otherwise keep the shifted remainder and set quotient LSB = 0.
  - Decrement counter. The edge on which the counter reaches 0 writes the final Hi/Lo, sets validOut = 1 and enters DONE.
- Latency: capture on edge 0, iterations on edges 1..WIDTH. validOut is high after edge WIDTH (32 for the default). Fixed latency, with no early termination.
- DONE:
  - validOut stays 1 and Hi/Lo stay stable until the next validIn is accepted or reset.
  - A new validIn in DONE restarts as from IDLE (back-to-back operations allowed).
- validIn while BUSY is ignored; the current division completes undisturbed.
- Hi/Lo are updated only on completion. During BUSY they hold the previous result, or 0 after reset.
- Divide by zero (SrcB = 0): no special case; the algorithm runs normally and gives Lo = all ones (0xFFFFFFFF) and Hi = SrcA. Latency is unchanged.
- SrcA < SrcB: Lo = 0, Hi = SrcA.
- Arithmetic invariant for SrcB ≠ 0: SrcA = Lo·SrcB + Hi, with Hi < SrcB.
- Fully synchronous except the reset; no combinational path from inputs to outputs.

Test Plan:
- Basic: reset, then SrcA = 412, SrcB = 412, validIn = 1 for one cycle.
  - validOut = 0 for 31 edges, then 1 after edge 32.
  - Hi = 0, Lo = 1; both stable while idle.
- Remainder: SrcA = 100, SrcB = 7 -> Lo = 14, Hi = 2. SrcA = 0xFFFFFFFF, SrcB = 1 -> Lo = 0xFFFFFFFF, Hi = 0.
- Edge operands:
  - SrcA = 5, SrcB = 9 -> Lo = 0, Hi = 5.
  - SrcB = 0, SrcA = 0x12345678 -> Lo = 0xFFFFFFFF, Hi = 0x12345678, latency 32.
- Handshake:
  - Pulse validIn again mid-operation with different operands -> ignored; first result correct at edge 32.
  - validIn in DONE with 1000/10 -> validOut drops next edge, then Lo = 100, Hi = 0 after 32 more edges.
- Reset: assert reset_n = 0 mid-BUSY.
  - validOut, Hi and Lo go to 0 immediately, without a clock edge.
  - After release, a new 412/412 completes normally.
- Random: 1000 random unsigned pairs with SrcB ≠ 0 -> SrcA = Lo·SrcB + Hi and Hi < SrcB, each completing in exactly 32 cycles.

Source files
------------

// File: rtl/div_iterative.sv
// div_iterative: restoring radix-2 unsigned divider, one quotient bit per clock.
// Hi = remainder, Lo = quotient; results update only on completion.
module div_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             validIn,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             validOut,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d, hi_q, hi_d, lo_q, lo_d;
    logic             valid_q, valid_d;
    logic [WIDTH:0]   rem_s, trial;
    logic             ge;
    always_comb begin
        rem_s   = {rem_q, quo_q[WIDTH-1]};
        trial   = rem_s - {1'b0, div_q};
        // Remainder stays below 2*divisor, so the borrow bit alone decides t >= 0.
        ge      = ~trial[WIDTH];
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        valid_d = valid_q;
        if (state_q == BUSY) begin
            rem_d = ge ? trial[WIDTH-1:0] : rem_s[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ge};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                hi_d    = rem_d;
                lo_d    = quo_d;
                valid_d = 1'b1;
                state_d = DONE;
            end
        end else if (validIn) begin
            rem_d   = '0;
            quo_d   = SrcA;
            div_d   = SrcB;
            cnt_d   = CW'(WIDTH);
            valid_d = 1'b0;
            state_d = BUSY;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            valid_q <= valid_d;
        end
    end
    assign validOut = valid_q;
    assign Hi       = hi_q;
    assign Lo       = lo_q;
endmodule

// File: tb/tb_div_iterative.sv
// tb_div_iterative: directed and random checks of the iterative divider.
module tb_div_iterative;
    logic        clk, reset_n, validIn, validOut;
    logic [31:0] SrcA, SrcB, Hi, Lo;
    int          nvec, errs, n;
    logic [31:0] a, b;

    div_iterative #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .validIn(validIn), .SrcA(SrcA), .SrcB(SrcB),
        .validOut(validOut), .Hi(Hi), .Lo(Lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives a one-cycle start strobe; returns at the negedge after the capture edge.
    task automatic start(input logic [31:0] da, input logic [31:0] db);
        @(negedge clk);
        SrcA = da;
        SrcB = db;
        validIn = 1'b1;
        @(negedge clk);
        validIn = 1'b0;
        SrcA = $urandom;
        SrcB = $urandom;
    endtask

    task automatic wait_done(input int n0, output int cnt);
        cnt = n0;
        while (!validOut && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] da, input logic [31:0] db,
                       input logic [31:0] q, input logic [31:0] r);
        int c;
        start(da, db);
        chk({tag, "_busy"}, {63'd0, validOut}, 64'd0);
        wait_done(0, c);
        chk({tag, "_lat"}, 64'(c), 64'd32);
        chk({tag, "_lo"}, {32'd0, Lo}, {32'd0, q});
        chk({tag, "_hi"}, {32'd0, Hi}, {32'd0, r});
    endtask

    initial begin
        nvec = 0;
        errs = 0;
        validIn = 1'b0;
        SrcA = '0;
        SrcB = '0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {63'd0, validOut}, 64'd0);
        chk("rst_hilo", {Hi, Lo}, 64'd0);
        reset_n = 1'b1;

        run("basic", 32'd412, 32'd412, 32'd1, 32'd0);
        repeat (5) @(negedge clk);
        chk("idle_stable", {Hi, Lo}, {32'd0, 32'd1});
        chk("idle_valid", {63'd0, validOut}, 64'd1);

        run("rem", 32'd100, 32'd7, 32'd14, 32'd2);
        run("max_div1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        run("a_lt_b", 32'd5, 32'd9, 32'd0, 32'd5);
        run("div0", 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);

        start(32'd100, 32'd7);
        repeat (10) @(negedge clk);
        chk("midop_hold", {Hi, Lo}, {32'h1234_5678, 32'hFFFF_FFFF});
        SrcA = 32'd5;
        SrcB = 32'd9;
        validIn = 1'b1;
        @(negedge clk);
        validIn = 1'b0;
        wait_done(11, n);
        chk("midop_lat", 64'(n), 64'd32);
        chk("midop_res", {Hi, Lo}, {32'd2, 32'd14});

        run("restart", 32'd1000, 32'd10, 32'd100, 32'd0);
        run("big", 32'h1234_5678, 32'h100, 32'h0012_3456, 32'h78);

        start(32'd412, 32'd412);
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, validOut}, 64'd0);
        chk("async_rst_hilo", {Hi, Lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {63'd0, validOut}, 64'd0);
        run("post_rst", 32'd412, 32'd412, 32'd1, 32'd0);

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(1) == 1) b = b >> $urandom_range(31);
            if (b == 0) b = 32'd1;
            start(a, b);
            wait_done(0, n);
            chk("rnd_lat", 64'(n), 64'd32);
            chk("rnd_inv", {63'd0, ({32'd0, Lo} * {32'd0, b} + {32'd0, Hi} == {32'd0, a}) && (Hi < b)}, 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
